// File: rtl/elev_pkg.sv
// Shared types and constants for the single-car elevator controller.
package elev_pkg;
  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;
  typedef enum logic [1:0] {NORMAL, UP_PEAK, DOWN_PEAK, OFF_PEAK} traffic_t;
  typedef logic [2:0] floor_t;

  localparam logic   DIR_UP    = 1'b1;
  localparam logic   DIR_DOWN  = 1'b0;
  localparam floor_t PARK_UP   = 3'd0;
  localparam floor_t PARK_DOWN = 3'd7;
  localparam floor_t PARK_OFF  = 3'd4;

  // Normal traffic parks where the car already is, i.e. never moves.
  function automatic floor_t park_target(input traffic_t t, input floor_t cur);
    case (t)
      UP_PEAK:   return PARK_UP;
      DOWN_PEAK: return PARK_DOWN;
      OFF_PEAK:  return PARK_OFF;
      default:   return cur;
    endcase
  endfunction
endpackage

// File: rtl/call_register.sv
// Hall-call bit registers plus above/below/at reductions relative to ref_floor.
module call_register
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  floor_t                request_floor,
  input  logic                  request_dir,
  input  floor_t                ref_floor,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_down,
  output logic [NUM_FLOORS-1:0] up_req,
  output logic [NUM_FLOORS-1:0] down_req,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  at_up,
  output logic                  at_down,
  output logic                  any_req
);
  logic [NUM_FLOORS-1:0] set_up, set_down, above_mask, below_mask, all_req;

  // Up at the top floor and down at the bottom floor are meaningless calls.
  always_comb begin
    set_up   = '0;
    set_down = '0;
    if (request) begin
      if (request_dir == DIR_UP && request_floor != floor_t'(NUM_FLOORS - 1))
        set_up[request_floor] = 1'b1;
      if (request_dir == DIR_DOWN && request_floor != '0)
        set_down[request_floor] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_mask
    assign above_mask[i] = (floor_t'(i) > ref_floor);
    assign below_mask[i] = (floor_t'(i) < ref_floor);
  end

  assign all_req   = up_req | down_req;
  assign any_above = |(all_req & above_mask);
  assign any_below = |(all_req & below_mask);
  assign at_up     = up_req[ref_floor];
  assign at_down   = down_req[ref_floor];
  assign any_req   = |all_req;

  // Set after clear: a fresh call survives a same-cycle clear of its bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_req   <= '0;
      down_req <= '0;
    end else begin
      up_req   <= (up_req & ~clr_up) | set_up;
      down_req <= (down_req & ~clr_down) | set_down;
    end
  end
endmodule

// File: rtl/top.sv
// Single-car collective-control elevator: car FSM (move / stop / door cycle)
// with parking chosen by traffic_state. Calls are held in call_register.
module top
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input logic       clk,
  input logic       reset,
  input logic       request,
  input logic [1:0] traffic_state,
  input logic [2:0] request_floor,
  input logic       request_dir
);
  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam floor_t         TOP_FLOOR   = floor_t'(NUM_FLOORS - 1);

  state_t                state, state_n;
  floor_t                current_floor, floor_n, park_floor, park_n;
  floor_t                step_floor, eval_floor, tgt;
  logic                  car_dir, dir_n, parking, parking_n;
  logic [TCW-1:0]        travel_cnt, travel_n;
  logic [DCW-1:0]        door_cnt, door_n;
  logic [NUM_FLOORS-1:0] up_req, down_req, clr_up, clr_down;
  logic                  any_above, any_below, at_up, at_down, any_req;
  logic                  at_end, travel_done, ahead, here_dir, here_opp, park_active;

  // On the arrival cycle all reductions are taken against the floor being entered.
  assign at_end      = car_dir ? (current_floor == TOP_FLOOR) : (current_floor == '0);
  assign step_floor  = car_dir ? current_floor + 3'd1 : current_floor - 3'd1;
  assign travel_done = (state == MOVING) && (travel_cnt == TRAVEL_LAST);
  assign eval_floor  = (travel_done && !at_end) ? step_floor : current_floor;
  assign ahead       = car_dir ? any_above : any_below;
  assign here_dir    = car_dir ? at_up : at_down;
  assign here_opp    = car_dir ? at_down : at_up;
  assign park_active = parking && !any_req;
  assign tgt         = park_target(traffic_t'(traffic_state), current_floor);

  call_register #(.NUM_FLOORS(NUM_FLOORS)) u_calls (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .request_floor(request_floor),
    .request_dir  (request_dir),
    .ref_floor    (eval_floor),
    .clr_up       (clr_up),
    .clr_down     (clr_down),
    .up_req       (up_req),
    .down_req     (down_req),
    .any_above    (any_above),
    .any_below    (any_below),
    .at_up        (at_up),
    .at_down      (at_down),
    .any_req      (any_req)
  );

  always_comb begin
    state_n   = state;
    floor_n   = current_floor;
    dir_n     = car_dir;
    travel_n  = travel_cnt;
    door_n    = door_cnt;
    parking_n = parking;
    park_n    = park_floor;
    clr_up    = '0;
    clr_down  = '0;
    case (state)
      IDLE: begin
        parking_n = 1'b0;
        if (at_up || at_down) begin
          state_n                 = DOOR_OPEN;
          door_n                  = '0;
          clr_up[current_floor]   = 1'b1;
          clr_down[current_floor] = 1'b1;
        end else if (any_above || any_below) begin
          state_n  = MOVING;
          travel_n = '0;
          if (!(any_above && any_below)) dir_n = any_above ? DIR_UP : DIR_DOWN;
        end else if (tgt != current_floor) begin
          state_n   = MOVING;
          travel_n  = '0;
          parking_n = 1'b1;
          park_n    = tgt;
          dir_n     = (tgt > current_floor) ? DIR_UP : DIR_DOWN;
        end
      end
      MOVING: begin
        // A real call cancels parking; the car finishes the current hop
        // and the arrival logic below decides what to do with the call.
        if (any_req) parking_n = 1'b0;
        if (!travel_done) begin
          travel_n = travel_cnt + 1'b1;
        end else begin
          travel_n = '0;
          if (at_end) begin
            state_n = IDLE;
          end else begin
            floor_n = step_floor;
            if (park_active) begin
              if (step_floor == park_floor) state_n = IDLE;
            end else if (here_dir || (!ahead && here_opp)) begin
              state_n = DOOR_OPEN;
              door_n  = '0;
              if (car_dir) clr_up[step_floor] = 1'b1;
              else         clr_down[step_floor] = 1'b1;
              if (!ahead) begin
                clr_up[step_floor]   = 1'b1;
                clr_down[step_floor] = 1'b1;
              end
            end else if (!ahead) begin
              state_n = IDLE;
            end
          end
        end
        if (state_n != MOVING) parking_n = 1'b0;
      end
      DOOR_OPEN: begin
        if (here_dir) begin
          door_n = '0;
          if (car_dir) clr_up[current_floor] = 1'b1;
          else         clr_down[current_floor] = 1'b1;
        end else if (door_cnt == DOOR_LAST) begin
          state_n = IDLE;
        end else begin
          door_n = door_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      car_dir       <= DIR_UP;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      parking       <= 1'b0;
      park_floor    <= '0;
    end else begin
      state         <= state_n;
      current_floor <= floor_n;
      car_dir       <= dir_n;
      travel_cnt    <= travel_n;
      door_cnt      <= door_n;
      parking       <= parking_n;
      park_floor    <= park_n;
    end
  end
endmodule

// File: tb/tb_top.sv
// Elevator bench: door-open events are scoreboarded (floor + cycle), car state probed directly.
module tb_top;
  import elev_pkg::*;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 8;

  logic       clk = 1'b0, reset = 1'b1, request = 1'b0, request_dir = 1'b0;
  logic [1:0] traffic_state = 2'd0;
  logic [2:0] request_floor = 3'd0;
  int         cyc = 0, n_chk = 0, n_err = 0;

  typedef struct { logic [2:0] floor; int cyc; } door_t;
  door_t  door_q[$];
  door_t  mon_e;
  state_t prev_st = IDLE;

  top dut (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .traffic_state(traffic_state),
    .request_floor(request_floor),
    .request_dir  (request_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic call(input logic [2:0] f, input logic d);
    request = 1'b1; request_floor = f; request_dir = d;
    @(negedge clk);
    request = 1'b0;
  endtask

  task automatic expect_door(input logic [2:0] f, input int c);
    door_t e;
    e.floor = f; e.cyc = c;
    door_q.push_back(e);
  endtask

  // Every entry into DOOR_OPEN must match the next expected stop.
  always @(negedge clk) begin
    if (dut.state == DOOR_OPEN && prev_st != DOOR_OPEN) begin
      chk("door_expected", 32'(door_q.size() != 0), 1);
      if (door_q.size() != 0) begin
        mon_e = door_q.pop_front();
        chk("door_floor", 32'(dut.current_floor), 32'(mon_e.floor));
        chk("door_cycle", cyc, mon_e.cyc);
      end
    end
    prev_st = dut.state;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k, d;
    @(negedge clk);
    chk("rst_floor", dut.current_floor, 0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_up", dut.up_req, 0);
    chk("rst_dn", dut.down_req, 0);
    chk("rst_dir", dut.car_dir, 1);
    chk("rst_park", dut.parking, 0);
    reset = 1'b0;

    // floor/dir wiggle with request low
    request_floor = 3'd1; request_dir = 1'b1;
    k = cyc; wait_to(k + 50);
    chk("noreq_up", dut.up_req, 0);
    chk("noreq_dn", dut.down_req, 0);
    chk("noreq_state", dut.state, IDLE);
    chk("noreq_floor", dut.current_floor, 0);

    // down call at floor 3 from floor 0
    k = cyc; expect_door(3, k + 2 + 3 * TRAVEL);
    call(3, 1'b0);
    chk("c3_dn", dut.down_req, 8'h08);
    wait_to(k + 2);  chk("c3_mov", dut.state, MOVING); chk("c3_dir", dut.car_dir, 1);
    wait_to(k + 6);  chk("c3_f1", dut.current_floor, 1);
    wait_to(k + 10); chk("c3_f2", dut.current_floor, 2);
    wait_to(k + 14); chk("c3_f3", dut.current_floor, 3); chk("c3_dn_clr", dut.down_req, 0);
    wait_to(k + 13 + DOOR); chk("c3_door_hold", dut.state, DOOR_OPEN);
    wait_to(k + 14 + DOOR); chk("c3_idle", dut.state, IDLE);

    // same-floor call, then a same-direction call restarts the door timer
    k = cyc; d = k + 2; expect_door(3, d);
    call(3, 1'b1);
    wait_to(d); chk("f3_up_clr", dut.up_req, 0);
    wait_to(d + 3); call(3, 1'b1);
    wait_to(d + 5); chk("restart_clr", dut.up_req, 0); chk("restart_cnt", dut.door_cnt, 0);
    wait_to(d + 4 + DOOR); chk("restart_hold", dut.state, DOOR_OPEN);
    wait_to(d + 5 + DOOR); chk("restart_idle", dut.state, IDLE);

    // up call below the car: reverse, opposite-direction stop at floor 0
    k = cyc; expect_door(0, k + 2 + 3 * TRAVEL);
    call(0, 1'b1);
    wait_to(k + 2); chk("f0_mov", dut.state, MOVING); chk("f0_dir", dut.car_dir, 0);
    wait_to(k + 14 + DOOR); chk("f0_idle", dut.state, IDLE); chk("f0_floor", dut.current_floor, 0);

    // call at the current floor opens next cycle
    k = cyc; expect_door(0, k + 2);
    call(0, 1'b1);
    wait_to(k + 2); chk("here_up_clr", dut.up_req, 0);
    wait_to(k + 2 + DOOR); chk("here_idle", dut.state, IDLE);

    // meaningless calls at the shaft ends are dropped
    k = cyc; call(7, 1'b1); chk("drop_up7", dut.up_req, 0);
    call(0, 1'b0); chk("drop_dn0", dut.down_req, 0);
    wait_to(k + 5); chk("drop_state", dut.state, IDLE); chk("drop_floor", dut.current_floor, 0);

    // down-peak parking to floor 7, no door
    k = cyc; traffic_state = 2'd2;
    wait_to(k + 1); chk("pk7_park", dut.parking, 1); chk("pk7_mov", dut.state, MOVING);
    wait_to(k + 28); chk("pk7_f6", dut.current_floor, 6); chk("pk7_mov2", dut.state, MOVING);
    wait_to(k + 29); chk("pk7_f7", dut.current_floor, 7); chk("pk7_idle", dut.state, IDLE);
    chk("pk7_park_clr", dut.parking, 0);

    // off-peak parking to floor 4
    k = cyc; traffic_state = 2'd3;
    wait_to(k + 13); chk("pk4_f4", dut.current_floor, 4); chk("pk4_idle", dut.state, IDLE);

    // up-peak parking aborted by a hall call, then resumed
    k = cyc; traffic_state = 2'd1; expect_door(2, k + 9);
    wait_to(k + 2); call(2, 1'b0);
    wait_to(k + 4); chk("abort_park", dut.parking, 0);
    wait_to(k + 26); chk("pk0_f0", dut.current_floor, 0); chk("pk0_idle", dut.state, IDLE);
    traffic_state = 2'd0;

    // reset in the middle of travel
    k = cyc; call(5, 1'b1);
    wait_to(k + 6); call(2, 1'b0);
    wait_to(k + 8);
    chk("mid_state", dut.state, MOVING); chk("mid_floor", dut.current_floor, 1);
    chk("mid_up", dut.up_req, 8'h20); chk("mid_dn", dut.down_req, 8'h04);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_state", dut.state, IDLE); chk("mrst_floor", dut.current_floor, 0);
    chk("mrst_dir", dut.car_dir, 1); chk("mrst_up", dut.up_req, 0);
    chk("mrst_dn", dut.down_req, 0); chk("mrst_tcnt", dut.travel_cnt, 0);
    chk("mrst_dcnt", dut.door_cnt, 0); chk("mrst_park", dut.parking, 0);
    reset = 1'b0;
    wait_to(k + 20); chk("post_state", dut.state, IDLE); chk("post_floor", dut.current_floor, 0);

    chk("door_sb_drained", door_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
